// File: rtl/elixirchip_es1_spu_stream_out.sv
// ---------------------------------------------------------------------------
// elixirchip_es1_spu_stream_out
//
// Output stage for the SPU op pipeline. Every op result qualified by
// cke && s_valid is captured into a small FIFO and presented on a registered
// ready/valid stream. The block also generates the pipeline's registered
// cke, so downstream back-pressure freezes the op chain instead of losing
// results that are already in flight.
//
// Storage is a FIFO_DEPTH-entry array plus one output register
// (m_data/m_valid). A write that finds the array empty and the output
// register free goes straight into the output register (1-cycle latency).
//
// Ports:
//   reset       in   synchronous, active-high reset
//   clk         in   clock
//   cke         out  registered clock enable to the upstream op pipeline
//   s_data      in   result from last op stage
//   s_valid     in   result qualifier, meaningful only while cke = 1
//   m_data      out  stream data (registered)
//   m_valid     out  stream valid (registered)
//   m_ready     in   stream ready
//   free_count  out  free array entries, 0..FIFO_DEPTH
//   overflow    out  sticky write-while-full flag
//
// Build option:
//   ELIXIRCHIP_ES1_SPU_STREAM_OUT_OVERFLOW_EN
//     defined   : overflow detection compiled in (sticky until reset; with
//                 SIMULATION = "true" a dropped write also raises $error)
//     undefined : overflow tied low; a write into a full array is still
//                 dropped without disturbing the pointers
// ---------------------------------------------------------------------------
module elixirchip_es1_spu_stream_out #(
   parameter int    DATA_BITS  = 8,
   parameter type   data_t     = logic [DATA_BITS-1:0],
   parameter int    FIFO_DEPTH = 16,
   parameter int    PTR_BITS   = $clog2(FIFO_DEPTH),
   parameter int    SLACK      = 1,
   parameter string DEVICE     = "RTL",
   parameter string SIMULATION = "false",
   parameter string DEBUG      = "false"
) (
   input  logic                reset,
   input  logic                clk,
   output logic                cke,
   input  data_t               s_data,
   input  logic                s_valid,
   output data_t               m_data,
   output logic                m_valid,
   input  logic                m_ready,
   output logic [PTR_BITS:0]   free_count,
   output logic                overflow
);

   localparam logic [PTR_BITS:0] DEPTH_C = (PTR_BITS+1)'(FIFO_DEPTH);
   localparam logic [PTR_BITS:0] SLACK_C = (PTR_BITS+1)'(SLACK);

   if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
       SLACK < 1 || SLACK >= FIFO_DEPTH) begin : g_param_check
      $error("%s: bad FIFO_DEPTH/SLACK (sim=%s debug=%s)", DEVICE, SIMULATION, DEBUG);
   end

   data_t               mem [FIFO_DEPTH];
   logic [PTR_BITS-1:0] wr_ptr;
   logic [PTR_BITS-1:0] rd_ptr;
   logic [PTR_BITS:0]   count;
   logic [PTR_BITS:0]   count_next;
   logic [PTR_BITS:0]   free_next;

   logic wr_evt;
   logic out_free;
   logic arr_empty;
   logic arr_full;
   logic arr_rd;
   logic bypass;
   logic arr_wr;

   always_comb begin
      wr_evt    = cke && s_valid;
      out_free  = !m_valid || m_ready;
      arr_empty = (count == '0);
      arr_full  = (count == DEPTH_C);
      arr_rd    = out_free && !arr_empty;
      // Bypass only when nothing older is queued, which keeps ordering intact.
      bypass    = out_free && arr_empty && wr_evt;
      // A full array still accepts a write when the head leaves the same cycle.
      arr_wr    = wr_evt && !bypass && (!arr_full || arr_rd);

      count_next = count;
      case ({arr_wr, arr_rd})
         2'b10:   count_next = count + 1'b1;
         2'b01:   count_next = count - 1'b1;
         default: count_next = count;
      endcase
      free_next = DEPTH_C - count_next;
   end

   // Array storage needs no reset; occupancy is tracked by count.
   always_ff @(posedge clk) begin
      if (arr_wr) begin
         mem[wr_ptr] <= s_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         free_count <= DEPTH_C;
         cke        <= 1'b0;
         m_valid    <= 1'b0;
         m_data     <= '0;
      end else begin
         if (arr_wr) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (arr_rd) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count      <= count_next;
         free_count <= free_next;
         // Decided on post-edge occupancy, so with SLACK >= 1 the one write
         // that can still land after cke drops always has a slot.
         cke        <= (free_next >= SLACK_C);
         if (out_free) begin
            m_valid <= arr_rd || bypass;
            if (arr_rd) begin
               m_data <= mem[rd_ptr];
            end else if (bypass) begin
               m_data <= s_data;
            end
         end
      end
   end

`ifdef ELIXIRCHIP_ES1_SPU_STREAM_OUT_OVERFLOW_EN
   logic drop;
   logic overflow_r;

   assign drop = wr_evt && !bypass && arr_full && !arr_rd;

   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_r <= 1'b0;
      end else if (drop) begin
         overflow_r <= 1'b1;
      end
   end

   assign overflow = overflow_r;

   if (SIMULATION == "true") begin : g_sim_report
      always_ff @(posedge clk) begin
         if (!reset && drop) begin
            $error("%s: stream_out write dropped, array full", DEVICE);
         end
      end
   end
`else
   assign overflow = 1'b0;
`endif

endmodule
